// File: rtl/serial_add_pkg.sv
// Shared definitions for the serial adder sequencer: FSM state encoding,
// default operand width and the bit driven onto the adder during FLUSH.
package serial_add_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FLUSH = 3'd1,
    ST_SHIFT = 3'd2,
    ST_CAPT  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam int SERIAL_ADD_WIDTH = 8;

  // a=b=0 clears the adder carry, a=b=1 sets it (carry-in for subtract)
  localparam logic FLUSH_BIT_ADD = 1'b0;
  localparam logic FLUSH_BIT_SUB = 1'b1;

  // Bit counter width: clog2 of the operand width, never narrower than 1
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/serial_shift_reg.sv
// Loadable right-shift register with serial input at the MSB end.
// Parallel load has priority over shifting.
module serial_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_en,
  input  logic             ser_in,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] shifted;

  generate
    if (WIDTH == 1) begin : g_one
      assign shifted = ser_in;
    end else begin : g_many
      assign shifted = {ser_in, q[WIDTH-1:1]};
    end
  endgenerate

  // Load, shift or hold the register contents
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= load_data;
    end else if (shift_en) begin
      q <= shifted;
    end
  end

endmodule

// File: rtl/serial_add_sequencer.sv
// Parallel-side controller for the carry-state serial adder: feeds operands
// LSB-first to the adder and collects sum bits plus the final carry.
// Build option: define SERIAL_ADD_SUB_EN to honour op_sub (A - B via ~B and
// a forced carry-in of 1); without it op_sub is ignored and only add exists.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | ready for operands, adder inputs held at 0
// FLUSH | one cycle of a=b=flush bit to set/clear the adder carry
// SHIFT | WIDTH cycles streaming operand bits, capturing sum bits
// CAPT  | one cycle latching the adder carry as carry_out
// DONE  | result presented until the consumer takes it
module serial_add_sequencer
  import serial_add_pkg::*;
#(
  parameter int WIDTH = SERIAL_ADD_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             op_sub,
  output logic             ser_a,
  output logic             ser_b,
  input  logic             ser_sum,
  input  logic             ser_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

`ifdef SERIAL_ADD_SUB_EN
  localparam logic SUB_EN = 1'b1;
`else
  localparam logic SUB_EN = 1'b0;
`endif

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             sub_sel;
  logic             flush_bit;
  logic [WIDTH-1:0] b_operand;
  logic             opnd_shift;
  logic             sum_shift;
  logic [WIDTH:0]   a_q;
  logic [WIDTH:0]   b_q;

  assign accept     = (state == ST_IDLE) && in_valid;
  assign sub_sel    = op_sub & SUB_EN;
  assign flush_bit  = sub_sel ? FLUSH_BIT_SUB : FLUSH_BIT_ADD;
  assign b_operand  = sub_sel ? ~op_b : op_b;
  assign opnd_shift = (state == ST_FLUSH) || (state == ST_SHIFT);
  assign sum_shift  = (state == ST_SHIFT);

  // The operand registers carry one extra LSB holding the flush bit, so
  // bit 0 is always the registered adder input: flush bit in FLUSH, operand
  // bits in SHIFT, and zeros (shifted in) from CAPT onward.
  serial_shift_reg #(.WIDTH(WIDTH + 1)) u_a_reg (
    .clk       (clk),
    .reset     (reset),
    .load      (accept),
    .load_data ({op_a, flush_bit}),
    .shift_en  (opnd_shift),
    .ser_in    (1'b0),
    .q         (a_q)
  );

  serial_shift_reg #(.WIDTH(WIDTH + 1)) u_b_reg (
    .clk       (clk),
    .reset     (reset),
    .load      (accept),
    .load_data ({b_operand, flush_bit}),
    .shift_en  (opnd_shift),
    .ser_in    (1'b0),
    .q         (b_q)
  );

  // Sum bits enter at the MSB so the first (LSB) sum bit ends at result[0]
  serial_shift_reg #(.WIDTH(WIDTH)) u_result_reg (
    .clk       (clk),
    .reset     (reset),
    .load      (1'b0),
    .load_data ({WIDTH{1'b0}}),
    .shift_en  (sum_shift),
    .ser_in    (ser_sum),
    .q         (result)
  );

  assign ser_a = a_q[0];
  assign ser_b = b_q[0];

  // Sequencer FSM with registered handshake flags and carry capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      carry_out <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            state    <= ST_FLUSH;
            cnt      <= '0;
            in_ready <= 1'b0;
          end
        end
        ST_FLUSH: begin
          state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST_BIT) begin
            state <= ST_CAPT;
          end
        end
        ST_CAPT: begin
          carry_out <= ser_carry;
          out_valid <= 1'b1;
          state     <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state     <= ST_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Directed bench for serial_add_sequencer: one WIDTH=8 and one WIDTH=1
// instance, each closed around a behavioural carry-state serial adder.
module tb_serial_add_sequencer;

`ifdef SERIAL_ADD_SUB_EN
  localparam logic SUB_BUILD = 1'b1;
`else
  localparam logic SUB_BUILD = 1'b0;
`endif

  int vectors_applied = 0;
  int miscompares     = 0;

  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  // WIDTH=8 instance signals
  logic       in_valid, in_ready, op_sub, ser_a, ser_b, ser_sum, ser_carry;
  logic       out_valid, out_ready, carry_out;
  logic [7:0] op_a, op_b, result;

  // WIDTH=1 instance signals
  logic       w1_in_valid, w1_in_ready, w1_op_sub, w1_ser_a, w1_ser_b;
  logic       w1_ser_sum, w1_ser_carry, w1_out_valid, w1_out_ready, w1_carry_out;
  logic [0:0] w1_op_a, w1_op_b, w1_result;

  serial_add_sequencer #(.WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_sub    (op_sub),
    .ser_a     (ser_a),
    .ser_b     (ser_b),
    .ser_sum   (ser_sum),
    .ser_carry (ser_carry),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry_out (carry_out)
  );

  serial_add_sequencer #(.WIDTH(1)) dut_w1 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (w1_in_valid),
    .in_ready  (w1_in_ready),
    .op_a      (w1_op_a),
    .op_b      (w1_op_b),
    .op_sub    (w1_op_sub),
    .ser_a     (w1_ser_a),
    .ser_b     (w1_ser_b),
    .ser_sum   (w1_ser_sum),
    .ser_carry (w1_ser_carry),
    .out_valid (w1_out_valid),
    .out_ready (w1_out_ready),
    .result    (w1_result),
    .carry_out (w1_carry_out)
  );

  // Behavioural serial adders: combinational sum, registered carry
  assign ser_sum    = ser_a ^ ser_b ^ ser_carry;
  assign w1_ser_sum = w1_ser_a ^ w1_ser_b ^ w1_ser_carry;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ser_carry    <= 1'b0;
      w1_ser_carry <= 1'b0;
    end else begin
      ser_carry    <= (ser_a & ser_b) | (ser_a & ser_carry) | (ser_b & ser_carry);
      w1_ser_carry <= (w1_ser_a & w1_ser_b) | (w1_ser_a & w1_ser_carry) |
                      (w1_ser_b & w1_ser_carry);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors_applied++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One WIDTH=8 operation; inputs driven and outputs sampled on negedges.
  // hold = cycles of backpressure in DONE, with fresh operands offered meanwhile.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic sub,
                      input logic [7:0] exp_res, input logic exp_cy,
                      input string tag, input int hold);
    int lat;
    logic [7:0] sa, sb, exp_b;
    logic sub_eff;
    sub_eff = sub & SUB_BUILD;
    exp_b   = sub_eff ? ~b : b;
    sa = '0;
    sb = '0;
    lat = 0;
    while (!in_ready && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_in_ready"}, in_ready, 1);
    in_valid = 1'b1;
    op_a = a;
    op_b = b;
    op_sub = sub;
    @(negedge clk);
    in_valid = 1'b0;
    op_a = 8'hC3;
    op_b = 8'h3C;
    chk({tag, "_flush_a"}, ser_a, sub_eff);
    chk({tag, "_busy"}, in_ready, 0);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat >= 1 && lat <= 8) begin
        sa[lat-1] = ser_a;
        sb[lat-1] = ser_b;
      end
    end
    chk({tag, "_latency"}, lat, 10);
    chk({tag, "_ser_a"}, sa, a);
    chk({tag, "_ser_b"}, sb, exp_b);
    chk({tag, "_result"}, result, exp_res);
    chk({tag, "_carry"}, carry_out, exp_cy);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      op_a = 8'h77;
      op_b = 8'h11;
      @(negedge clk);
      chk({tag, "_hold_valid"}, out_valid, 1);
      chk({tag, "_hold_result"}, result, exp_res);
      chk({tag, "_hold_carry"}, carry_out, exp_cy);
      chk({tag, "_hold_in_ready"}, in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_ret_idle_ready"}, in_ready, 1);
    chk({tag, "_ret_idle_valid"}, out_valid, 0);
  endtask

  task automatic run1(input logic a, input logic b, input logic exp_res,
                      input logic exp_cy, input string tag);
    int lat;
    lat = 0;
    while (!w1_in_ready && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_in_ready"}, w1_in_ready, 1);
    w1_in_valid = 1'b1;
    w1_op_a = a;
    w1_op_b = b;
    @(negedge clk);
    w1_in_valid = 1'b0;
    lat = 0;
    while (!w1_out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat == 1) chk({tag, "_ser_a"}, w1_ser_a, a);
    end
    chk({tag, "_latency"}, lat, 3);
    chk({tag, "_result"}, w1_result, exp_res);
    chk({tag, "_carry"}, w1_carry_out, exp_cy);
    w1_out_ready = 1'b1;
    @(negedge clk);
    w1_out_ready = 1'b0;
    chk({tag, "_ret_idle"}, w1_in_ready, 1);
  endtask

  initial begin
    in_valid = 0; op_a = 0; op_b = 0; op_sub = 0; out_ready = 0;
    w1_in_valid = 0; w1_op_a = 0; w1_op_b = 0; w1_op_sub = 0; w1_out_ready = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_carry", carry_out, 0);
    chk("rst_ser_ab", {ser_a, ser_b}, 0);

    run8(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, "add_5a_3c", 0);
    run8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "add_ff_01", 0);
    run8(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, "add_00_00", 0);
    run8(8'hC8, 8'h64, 1'b0, 8'h2C, 1'b1, "add_c8_64", 0);
    run8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, "add_7f_01", 0);
    run8(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, "backpressure", 5);

    // Abort in the 4th SHIFT cycle of 0xAA+0x55
    chk("abort_in_ready", in_ready, 1);
    in_valid = 1'b1;
    op_a = 8'hAA;
    op_b = 8'h55;
    op_sub = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_partial", result, 8'hE0);
    chk("abort_pre_valid", out_valid, 0);
    reset = 1'b1;
    #1;
    chk("abort_result", result, 0);
    chk("abort_carry", carry_out, 0);
    chk("abort_ser_ab", {ser_a, ser_b}, 0);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_in_ready_rst", in_ready, 1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_no_result", out_valid, 0);
    run8(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, "after_abort", 0);

`ifdef SERIAL_ADD_SUB_EN
    run8(8'h10, 8'h01, 1'b1, 8'h0F, 1'b1, "sub_10_01", 0);
    run8(8'h01, 8'h02, 1'b1, 8'hFF, 1'b0, "sub_01_02", 0);
`else
    run8(8'h10, 8'h01, 1'b1, 8'h11, 1'b0, "nosub_10_01", 0);
    run8(8'h01, 8'h02, 1'b1, 8'h03, 1'b0, "nosub_01_02", 0);
`endif
    run8(8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, "add_after_sub", 0);

    run1(1'b1, 1'b1, 1'b0, 1'b1, "w1_1_1");
    run1(1'b1, 1'b0, 1'b1, 1'b0, "w1_1_0");
    run1(1'b0, 1'b0, 1'b0, 1'b0, "w1_0_0");

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
